ram_input_reader: RTL and testbench

- Streams a contiguous run of 1-bit input samples out of the 1024x1 input RAM (registered read address, 1-cycle read latency) to the downstream compute datapath.
- Issues RAM read addresses, absorbs the read latency and presents bits on a valid/ready stream with backpressure.
- Sits between the input RAM's read port and the first-layer MAC unit. It never drives the RAM's write side.

---
 rtl/ram_input_reader_pkg.sv | 18 +
 rtl/ram_input_reader_buf.sv | 50 +++++
 rtl/ram_input_reader.sv | 146 ++++++++++++++
 tb/tb_ram_input_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_input_reader_pkg.sv
// rtl/ram_input_reader_pkg.sv - shared parameters, FSM state type and buffer sizing for ram_input_reader
package ram_input_reader_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 11;

  // Two slots cover the one-cycle RAM latency plus one bit held under backpressure
  localparam int BUF_DEPTH  = 2;
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_input_reader_buf.sv
// rtl/ram_input_reader_buf.sv - 2-entry 1-bit FIFO holding RAM read data until the consumer takes it
module ram_input_reader_buf
  import ram_input_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_data,
  input  logic             pop,
  output logic             head,
  output logic [OCC_W-1:0] occupancy
);

  logic [BUF_DEPTH-1:0] mem;
  // Single-bit pointers are enough because the depth is exactly two
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [OCC_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < OCC_W'(BUF_DEPTH)) || do_pop);
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  // Storage, pointers and fill level; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_input_reader.sv
// rtl/ram_input_reader.sv - streams a run of bits from the input RAM onto a valid/ready stream (optional RAM_INPUT_READER_POPCOUNT_EN)
module ram_input_reader
  import ram_input_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic              busy,
  output logic              done
`ifdef RAM_INPUT_READER_POPCOUNT_EN
  ,
  output logic [LEN_W-1:0]  ones_count
`endif
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] issue_ptr;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  out_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic              in_flight;
  logic [OCC_W-1:0]  occ;
  logic              head;
  logic              start_ok;
  logic              issue;
  logic              xfer;
  logic [2:0]        slots;

  assign start_ok  = (state == IDLE) && start;
  assign bit_valid = (occ != '0);
  assign bit_out   = head;
  assign xfer      = bit_valid && bit_ready;
  assign bit_last  = bit_valid && (out_cnt == LEN_W'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // A pop in this cycle frees its slot in time for the data of a read issued now,
  // which is what keeps one bit per cycle flowing under continuous ready
  assign slots     = 3'(occ) + 3'(in_flight) - 3'(xfer);
  assign issue     = (state == RUN) && (issue_cnt != '0) && (slots < 3'd2);

  // The address is presented in the issue cycle; otherwise the last one is held
  assign ram_addr  = issue ? issue_ptr : addr_hold;

  ram_input_reader_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (ram_q),
    .pop       (xfer),
    .head      (head),
    .occupancy (occ)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue && (issue_cnt == LEN_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && bit_last) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read pointer, issue/output counters and the read-in-flight flag
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_ptr <= '0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      addr_hold <= '0;
      in_flight <= 1'b0;
    end else begin
      addr_hold <= ram_addr;
      in_flight <= issue;
      if (start_ok) begin
        issue_ptr <= base_addr;
        issue_cnt <= length;
        out_cnt   <= length;
      end else begin
        if (issue) begin
          issue_ptr <= issue_ptr + ADDR_W'(1);
          issue_cnt <= issue_cnt - LEN_W'(1);
        end
        if (xfer) begin
          out_cnt <= out_cnt - LEN_W'(1);
        end
      end
    end
  end

`ifdef RAM_INPUT_READER_POPCOUNT_EN
  // Count delivered ones; cleared by an accepted start and frozen once the run ends
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_count <= '0;
    end else if (start_ok) begin
      ones_count <= '0;
    end else if (xfer && bit_out) begin
      ones_count <= ones_count + LEN_W'(1);
    end
  end
`else
  // No side counters: the stream is the only output of a run
`endif

endmodule

// File: tb/tb_ram_input_reader.sv
// tb/tb_ram_input_reader.sv - directed table-driven bench for ram_input_reader
module tb_ram_input_reader;
  import ram_input_reader_pkg::*;

  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic [AW-1:0] ram_addr;
  logic          ram_q;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          bit_last;
  logic          busy;
  logic          done;
`ifdef RAM_INPUT_READER_POPCOUNT_EN
  logic [LW-1:0] ones_count;
`endif

  logic mem [0:1023];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Behavioural RAM: address captured at the edge, data available the cycle after
  always @(posedge clk) ram_q <= mem[ram_addr];

  ram_input_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .busy      (busy),
    .done      (done)
`ifdef RAM_INPUT_READER_POPCOUNT_EN
    ,
    .ones_count(ones_count)
`endif
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [15:0]   data;
    logic [31:0]   rdy;
    int            poke_cyc;
    int            exp_done;
    int            exp_ones;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int            cyc;
    int            got;
    int            issued;
    int            first_valid;
    bit            fin;
    bit            prev_stall;
    logic          prev_bit;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] exp_addr;
    for (int j = 0; j < int'(v.len); j++) begin
      mem[AW'(int'(v.base) + j)] = v.data[j];
    end
    @(negedge clk);
    base_addr = v.base;
    length    = v.len;
    start     = 1'b1;
    bit_ready = 1'b1;
    #1 prev_addr = ram_addr;
    @(negedge clk);
    start       = 1'b0;
    cyc         = 0;
    got         = 0;
    issued      = 0;
    first_valid = -1;
    fin         = 1'b0;
    prev_stall  = 1'b0;
    prev_bit    = 1'b0;
    while (!fin && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == v.poke_cyc) begin
        start     = 1'b1;
        base_addr = AW'(5);
        length    = LW'(7);
      end else begin
        start = 1'b0;
      end
      bit_ready = (cyc < 32) ? v.rdy[cyc] : 1'b1;
      #1;
      if (v.len == '0) begin
        check($sformatf("v%0d_addr_idle_c%0d", id, cyc), int'(ram_addr), int'(prev_addr));
      end else if (cyc == 0) begin
        check($sformatf("v%0d_addr_first", id), int'(ram_addr), int'(v.base));
        issued = 1;
      end else if (ram_addr != prev_addr) begin
        exp_addr = AW'(int'(v.base) + issued);
        check($sformatf("v%0d_addr%0d", id, issued), int'(ram_addr), int'(exp_addr));
        issued++;
      end
      prev_addr = ram_addr;
      if (bit_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check($sformatf("v%0d_hold_c%0d", id, cyc), int'(bit_out), int'(prev_bit));
      end
      if (bit_valid) begin
        check($sformatf("v%0d_last_c%0d", id, cyc), int'(bit_last), int'(got == int'(v.len) - 1));
      end
      if (bit_valid && bit_ready) begin
        check($sformatf("v%0d_bit%0d", id, got), int'(bit_out), int'(v.data[got]));
        got++;
      end
      check($sformatf("v%0d_outstanding_c%0d", id, cyc), int'((issued - got) > 2), 0);
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      if (done) fin = 1'b1;
      else cyc++;
    end
    start = 1'b0;
    check($sformatf("v%0d_done_cycle", id), cyc, v.exp_done);
    check($sformatf("v%0d_bits_delivered", id), got, int'(v.len));
    check($sformatf("v%0d_reads_issued", id), issued, int'(v.len));
    check($sformatf("v%0d_first_valid", id), first_valid, (v.len == '0) ? -1 : 2);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_busy_after", id), int'(busy), 0);
    check($sformatf("v%0d_done_after", id), int'(done), 0);
    check($sformatf("v%0d_valid_after", id), int'(bit_valid), 0);
`ifdef RAM_INPUT_READER_POPCOUNT_EN
    check($sformatf("v%0d_ones_count", id), int'(ones_count), v.exp_ones);
`endif
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{base: 10'd0,    len: 11'd4, data: 16'b1101,      rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 6,  exp_ones: 3};
    vecs[1] = '{base: 10'd0,    len: 11'd4, data: 16'b1101,      rdy: 32'hFFFFF547, poke_cyc: -1, exp_done: 11, exp_ones: 3};
    vecs[2] = '{base: 10'd1022, len: 11'd4, data: 16'b1001,      rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 6,  exp_ones: 2};
    vecs[3] = '{base: 10'd7,    len: 11'd0, data: 16'b0,         rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 0,  exp_ones: 0};
    vecs[4] = '{base: 10'd0,    len: 11'd4, data: 16'b1101,      rdy: 32'hFFFFFFFF, poke_cyc: 2,  exp_done: 6,  exp_ones: 3};
    vecs[5] = '{base: 10'd100,  len: 11'd9, data: 16'h0165,      rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 11, exp_ones: 5};
    vecs[6] = '{base: 10'd1023, len: 11'd1, data: 16'b1,         rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 3,  exp_ones: 1};

    for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom_range(0, 1));
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    bit_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid", int'(bit_valid), 0);
    check("reset_last", int'(bit_last), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(ram_addr), 0);
`ifdef RAM_INPUT_READER_POPCOUNT_EN
    check("reset_ones", int'(ones_count), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    for (int j = 0; j < 8; j++) mem[j] = 1'(j % 2 == 0);
    @(negedge clk);
    base_addr = '0;
    length    = LW'(8);
    bit_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pre_valid", int'(bit_valid), 1);
    check("rst_pre_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_valid", int'(bit_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_addr", int'(ram_addr), 0);
    rst = 1'b0;
    rv = '{base: 10'd0, len: 11'd2, data: 16'b01, rdy: 32'hFFFFFFFF, poke_cyc: -1, exp_done: 4, exp_ones: 1};
    run_vec(rv, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
